// File: rtl/mlp_fc_layer_if.sv
// Handshake bundle for mlp_fc_layer: weight side channel, activation stream and result stream.
interface mlp_fc_layer_if #(
  parameter int DW    = 16,
  parameter int N_OUT = 3,
  parameter int LW    = 2,
  parameter int SW    = 4
);
  logic                w_tvalid;
  logic [LW-1:0]       w_tlane;
  logic [SW-1:0]       w_tslot;
  logic [DW-1:0]       w_tdata;

  logic                s_tvalid;
  logic                s_tready;
  logic [DW-1:0]       s_tdata;
  logic                s_tlast;

  logic                m_tvalid;
  logic                m_tready;
  logic [N_OUT*DW-1:0] m_tdata;

  modport master (
    output w_tvalid, w_tlane, w_tslot, w_tdata,
    output s_tvalid, s_tdata, s_tlast,
    input  s_tready,
    input  m_tvalid, m_tdata,
    output m_tready
  );

  modport slave (
    input  w_tvalid, w_tlane, w_tslot, w_tdata,
    input  s_tvalid, s_tdata, s_tlast,
    output s_tready,
    output m_tvalid, m_tdata,
    input  m_tready
  );
endinterface

// File: rtl/mlp_fc_layer.sv
// Fully-connected MLP layer: serial activations MAC'd into N_OUT lanes, biased, rescaled, saturated.
// Define MLP_RELU_EN to clamp negative lane results to zero (hidden-layer build).
module mlp_fc_layer #(
  parameter int DW     = 16,
  parameter int FRAC   = 8,
  parameter int N_OUT  = 3,
  parameter int MAX_IN = 8,
  parameter int LW     = 2,
  parameter int SW     = 4
) (
  input  logic          aclk,
  input  logic          aresetn,
  mlp_fc_layer_if.slave bus,
  input  logic [SW-1:0] in_dim,
  output logic          err,
  input  logic          err_clr
);
  // state    | meaning
  // ST_ACC   | accepting activations, every lane accumulates x * w[cnt]
  // ST_FINAL | one cycle: add bias, rescale, saturate, register result
  // ST_OUT   | result presented, waiting for m_tready
  localparam int ACCW = 2*DW + $clog2(MAX_IN) + 1;
  localparam int SUMW = ACCW + 1;

  typedef enum logic [1:0] {ST_ACC, ST_FINAL, ST_OUT} state_t;
  state_t state, state_nxt;

  logic signed [DW-1:0]   w_mem [N_OUT][MAX_IN+1];
  logic signed [ACCW-1:0] acc   [N_OUT];
  logic signed [2*DW-1:0] prod  [N_OUT];

  logic [LW-1:0]       w_lane;
  logic [SW-1:0]       w_slot;
  logic                w_hit;
  logic [SW-1:0]       cnt, d_lat, d_in, d_cur;
  logic                rdy_q, beat, cnt_end, vec_end, frame_err, clr_acc;
  logic [N_OUT*DW-1:0] res, m_data_q;

  assign w_lane = bus.w_tlane;
  assign w_slot = bus.w_tslot;
  assign w_hit  = bus.w_tvalid && (int'(w_lane) < N_OUT) && (int'(w_slot) <= MAX_IN);

  // Coefficient store is deliberately unreset; the MAC reads the pre-edge value on a same-cycle write.
  always_ff @(posedge aclk) begin
    if (w_hit) w_mem[w_lane][w_slot] <= bus.w_tdata;
  end

  assign d_in      = (in_dim == '0 || int'(in_dim) > MAX_IN) ? SW'(MAX_IN) : in_dim;
  assign d_cur     = (cnt == '0) ? d_in : d_lat;
  assign beat      = bus.s_tvalid && rdy_q;
  assign cnt_end   = (cnt == d_cur - SW'(1));
  assign vec_end   = beat && (bus.s_tlast || cnt_end);
  assign frame_err = beat && (bus.s_tlast != cnt_end);
  assign clr_acc   = (state == ST_OUT) && bus.m_tready;

  assign bus.s_tready = rdy_q;
  assign bus.m_tdata  = m_data_q;

  always_comb begin
    for (int l = 0; l < N_OUT; l++) begin
      prod[l] = $signed({{DW{bus.s_tdata[DW-1]}}, bus.s_tdata}) *
                $signed({{DW{w_mem[l][cnt][DW-1]}}, w_mem[l][cnt]});
    end
  end

  function automatic logic [DW-1:0] post_proc(input logic signed [ACCW-1:0] a,
                                              input logic signed [DW-1:0]   b);
    logic signed [SUMW-1:0] s;
    logic signed [SUMW-1:0] r;
    logic signed [SUMW-1:0] lim_hi;
    logic signed [SUMW-1:0] lim_lo;
    logic [DW-1:0]          q;
    lim_hi = $signed({{(SUMW-DW+1){1'b0}}, {(DW-1){1'b1}}});
    lim_lo = $signed({{(SUMW-DW+1){1'b1}}, {(DW-1){1'b0}}});
    s = $signed({{(SUMW-ACCW){a[ACCW-1]}}, a}) +
        $signed({{(SUMW-DW-FRAC){b[DW-1]}}, b, {FRAC{1'b0}}});
    r = s >>> FRAC;
    if (r > lim_hi)      q = lim_hi[DW-1:0];
    else if (r < lim_lo) q = lim_lo[DW-1:0];
    else                 q = r[DW-1:0];
`ifdef MLP_RELU_EN
    if (q[DW-1]) q = '0;
`endif
    return q;
  endfunction

  always_comb begin
    res = '0;
    for (int l = 0; l < N_OUT; l++) begin
      res[l*DW +: DW] = post_proc(acc[l], w_mem[l][MAX_IN]);
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.m_tvalid = 1'b0;
    unique case (state)
      ST_ACC:   if (vec_end) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_OUT;
      ST_OUT: begin
        bus.m_tvalid = 1'b1;
        if (bus.m_tready) state_nxt = ST_ACC;
      end
      default:  state_nxt = ST_ACC;
    endcase
  end

  // s_tready is registered so it stays low while aresetn is asserted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_ACC;
      rdy_q    <= 1'b0;
      cnt      <= '0;
      d_lat    <= '0;
      m_data_q <= '0;
      err      <= 1'b0;
      for (int l = 0; l < N_OUT; l++) acc[l] <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == ST_ACC);

      if (clr_acc)   cnt <= '0;
      else if (beat) cnt <= cnt + SW'(1);

      if (beat && cnt == '0) d_lat <= d_in;

      for (int l = 0; l < N_OUT; l++) begin
        if (clr_acc)   acc[l] <= '0;
        else if (beat) acc[l] <= acc[l] + $signed({{(ACCW-2*DW){prod[l][2*DW-1]}}, prod[l]});
      end

      if (state == ST_FINAL) m_data_q <= res;

      if (frame_err)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
endmodule

// File: doc/mlp_fc_layer.md
Name: mlp_fc_layer

Overview:
Parametrised fully-connected MLP layer engine, the successor to the fixed 3-lane layer stages.
- Consumes one serial activation per beat on an AXI-stream-style input.
- Accumulates multiply-accumulate in N_OUT parallel lanes, one lane per output neuron.
- Adds a per-lane bias, rescales from fixed point, saturates and emits all lanes as one wide output beat.
- Weights and biases load through a side channel shared by all layers. Input dimension is runtime-programmable.

Parameters:
DW, 16, activation/weight/output width (signed, two's complement)
FRAC, 8, fractional bits of the Q format (product shifted right by FRAC)
N_OUT, 3, number of output lanes/neurons
MAX_IN, 8, maximum input dimension; also sets weight slots per lane
LW, 2, lane-select width on weight channel (>= clog2(N_OUT))
SW, 4, slot-select width on weight channel (>= clog2(MAX_IN+1))

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
w_tvalid  in  1  weight write strobe
w_tlane  in  LW  target lane
w_tslot  in  SW  slot: 0..MAX_IN-1 weight index, MAX_IN bias
w_tdata  in  DW  weight/bias value
in_dim  in  SW  runtime input dimension; sampled at the first beat of a vector
s_tvalid  in  1  activation valid
s_tready  out  1  activation ready
s_tdata  in  DW  activation
s_tlast  in  1  last activation of vector
m_tvalid  out  1  result valid
m_tready  in  1  result ready
m_tdata  out  N_OUT*DW  lane l at bits [l*DW +: DW]
err  out  1  sticky framing error
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset is aresetn, asynchronous, active-low; clock is aclk.
- Reset values:
  - state ACC, accumulators 0, beat counter 0.
  - s_tready 0 during reset, 1 in the first cycle after release.
  - m_tvalid 0, m_tdata 0, err 0.
  - Weight/bias storage is NOT reset.
- Weight write: on w_tvalid, store w_tdata into lane w_tlane, slot w_tslot.
  - Writes with w_tlane>=N_OUT or w_tslot>MAX_IN are ignored.
  - Writes are accepted in any state.
  - A write and a MAC read of the same slot in the same cycle: the MAC uses the old value.
- Effective dimension: D = in_dim, except in_dim=0 or in_dim>MAX_IN gives D = MAX_IN. D is latched at the beat where the counter is 0.
- Accumulator width: 2*DW + clog2(MAX_IN) + 1, signed.
- State ACC:
  - s_tready = 1.
  - On each s_tvalid&&s_tready, every lane l does acc[l] += s_tdata * w[l][cnt], and cnt increments.
  - Vector end is the first of: s_tlast accepted, or cnt reaches D-1 on an accepted beat.
  - Framing error: if the two end conditions do not coincide, set err. This covers s_tlast before D beats, and D beats without s_tlast. In both cases the vector terminates and goes to FINAL.
- State FINAL (1 cycle, s_tready=0):
  - Per lane: r = (acc + (bias << FRAC)) >>> FRAC (arithmetic shift, truncation toward -inf).
  - Saturate r to DW bits: > 0x7FFF gives 0x7FFF, < 0x8000 gives 0x8000 (DW=16).
  - Register the result into m_tdata and go to OUT.
- State OUT:
  - m_tvalid = 1; m_tdata is held stable until m_tvalid&&m_tready.
  - s_tready = 0.
  - On the handshake: clear accumulators and cnt, drop m_tvalid, return to ACC. s_tready rises the next cycle.
- Latency:
  - Last beat handshake at edge k, FINAL in the cycle after edge k, m_tvalid high after edge k+1.
  - Sustained throughput: D+2 cycles per vector with m_tready tied high.
- err:
  - Set on a framing error and held.
  - err_clr clears it. If err_clr and a new error occur in the same cycle, set wins.
- Reset mid-vector discards the partial accumulation and any pending output. The next vector starts at cnt 0.

Optional Feature:
MLP_RELU_EN
- Defined: after saturation, any negative lane result is replaced by 0x0000. Hidden layers instantiate with it.
- Undefined: results pass through signed, unclamped, for the output layer.
- Latency is identical in both builds.

Test Plan:
- Basic MAC, Q8.8, in_dim=4:
  - Setup: lane0 weights 0x0100 ×4, bias0 0; x = 0x0100,0x0200,0x0300,0x0400 with s_tlast on beat 4.
  - Required: lane0 = 0x0A00, m_tvalid 2 cycles after the last beat, err 0.
- Negative and ReLU:
  - Setup: lane1 weights 0xFF00 ×4, bias1 0x0080, same x.
  - Required: lane1 = 0xF680 without MLP_RELU_EN, 0x0000 with it.
- Saturation:
  - Setup: all weights 0x7F00, x = 0x7F00 ×4.
  - Required: every lane 0x7FFF. With weights 0x8100, every lane 0x8000 (non-ReLU build).
- Framing:
  - in_dim=4, s_tlast on beat 2 → output after 2 beats, err=1.
  - err_clr pulse → err=0.
  - Next vector of 4 beats without s_tlast → output after beat 4, err=1.
- Backpressure: hold m_tready low 5 cycles → m_tdata stable, s_tready 0 throughout; on release, one handshake and s_tready=1 the next cycle.
- Reset mid-vector and clamp:
  - Assert aresetn low after beat 2 of 4 → m_tvalid 0.
  - Next 4-beat vector produces the same result as the basic case (weights retained).
  - in_dim=0 behaves as MAX_IN=8.
